// File: rtl/alu_inst_sequencer.sv
// alu_inst_sequencer: decodes one R-type instruction per handshake and sequences the
// operand-latch / result-latch / write-back phase strobes for the datapath stage.
module alu_inst_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst,
  input  logic             inst_valid,
  output logic             inst_ready,
  output logic [4:0]       R_Addr_A,
  output logic [4:0]       R_Addr_B,
  output logic [4:0]       W_Addr,
  output logic [3:0]       ALU_OP,
  output logic             Reg_Write,
  output logic             clk_RR,
  output logic             clk_F,
  output logic             clk_WB,
  output logic             ill_flag,
  output logic [CNT_W-1:0] inst_cnt
);
  typedef enum logic [2:0] {IDLE, DEC, RR, EX, WB, ILL} state_t;
  state_t state, state_nx;
  logic [31:0] ir;
  logic [3:0] op_dec;
  logic legal_dec, legal_q;
  always_comb begin
    op_dec = 4'd0;
    legal_dec = inst[31:26] == 6'd0;
    case (inst[5:0])
      6'b100100: op_dec = 4'd0;
      6'b100101: op_dec = 4'd1;
      6'b100110: op_dec = 4'd2;
      6'b100111: op_dec = 4'd3;
      6'b100000: op_dec = 4'd4;
      6'b100010: op_dec = 4'd5;
      6'b101011: op_dec = 4'd6;
      6'b000100: op_dec = 4'd7;
      default:   legal_dec = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = inst_valid ? DEC : IDLE;
      DEC:     state_nx = legal_q ? RR : ILL;
      RR:      state_nx = EX;
      EX:      state_nx = WB;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    inst_ready = state == IDLE;
    clk_RR = state == RR;
    clk_F = state == EX;
    clk_WB = state == WB;
    Reg_Write = (state == EX || state == WB) && |ir[15:11];
  end
  // IR and the decoded op only change on accept, so the address/op outputs hold between instructions
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ir <= '0;
      ALU_OP <= '0;
      legal_q <= 1'b0;
      ill_flag <= 1'b0;
      inst_cnt <= '0;
    end else begin
      if (state == IDLE && inst_valid) begin
        ir <= inst;
        ALU_OP <= op_dec;
        legal_q <= legal_dec;
      end
      if (state == ILL) ill_flag <= 1'b1;
      if (state == WB) inst_cnt <= inst_cnt + 1'b1;
    end
  assign R_Addr_A = ir[25:21];
  assign R_Addr_B = ir[20:16];
  assign W_Addr = ir[15:11];
endmodule

// File: tb/tb_alu_inst_sequencer.sv
// tb_alu_inst_sequencer: directed instruction stream with a scoreboard queue; a monitor pops
// expectations on every clk_RR and follows the instruction through clk_F/clk_WB.
module tb_alu_inst_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, inst_valid = 1'b0;
  logic [31:0] inst = '0;
  logic inst_ready, Reg_Write, clk_RR, clk_F, clk_WB, ill_flag;
  logic [4:0] R_Addr_A, R_Addr_B, W_Addr;
  logic [3:0] ALU_OP;
  logic [15:0] inst_cnt;
  logic inst_ready_4, Reg_Write_4, clk_RR_4, clk_F_4, clk_WB_4, ill_flag_4;
  logic [4:0] R_Addr_A_4, R_Addr_B_4, W_Addr_4;
  logic [3:0] ALU_OP_4, inst_cnt_4;
  alu_inst_sequencer dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr), .ALU_OP(ALU_OP),
    .Reg_Write(Reg_Write), .clk_RR(clk_RR), .clk_F(clk_F), .clk_WB(clk_WB),
    .ill_flag(ill_flag), .inst_cnt(inst_cnt)
  );
  alu_inst_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready_4),
    .R_Addr_A(R_Addr_A_4), .R_Addr_B(R_Addr_B_4), .W_Addr(W_Addr_4), .ALU_OP(ALU_OP_4),
    .Reg_Write(Reg_Write_4), .clk_RR(clk_RR_4), .clk_F(clk_F_4), .clk_WB(clk_WB_4),
    .ill_flag(ill_flag_4), .inst_cnt(inst_cnt_4)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0] ra, rb, wa;
    logic [3:0] op;
    logic rw;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  int total = 0, bad = 0, cnt_m = 0;
  bit ill_m = 0, cnt_pend = 0, prev_rr = 0, prev_f = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      cnt_pend = 0;
      prev_rr = 0;
      prev_f = 0;
    end else begin
      if (cnt_pend) begin
        chk("cnt_after_wb", 32'(inst_cnt), 32'(cur.cnt));
        chk("cnt4_after_wb", 32'(inst_cnt_4), 32'(cur.cnt[3:0]));
        cnt_pend = 0;
      end
      if (clk_RR | clk_F | clk_WB) chk("strobe_onehot", 32'($onehot({clk_RR, clk_F, clk_WB})), 32'd1);
      else chk("rw_no_strobe", 32'(Reg_Write), 32'd0);
      if (clk_RR) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rr: got clk_RR=1 required no strobe");
        end else begin
          cur = q.pop_front();
          chk("rr_addr_a", 32'(R_Addr_A), 32'(cur.ra));
          chk("rr_addr_b", 32'(R_Addr_B), 32'(cur.rb));
          chk("rr_w_addr", 32'(W_Addr), 32'(cur.wa));
          chk("rr_alu_op", 32'(ALU_OP), 32'(cur.op));
          chk("rr_rw", 32'(Reg_Write), 32'd0);
        end
      end
      if (clk_F) begin
        chk("f_after_rr", 32'(prev_rr), 32'd1);
        chk("rw_ex", 32'(Reg_Write), 32'(cur.rw));
      end
      if (clk_WB) begin
        chk("wb_after_f", 32'(prev_f), 32'd1);
        chk("rw_wb", 32'(Reg_Write), 32'(cur.rw));
        chk("wb_w_addr", 32'(W_Addr), 32'(cur.wa));
        cnt_pend = 1;
      end
      prev_rr = clk_RR;
      prev_f = clk_F;
    end
  end
  function automatic exp_t mk(input logic [31:0] w, input logic [3:0] op, input int cnt);
    exp_t e;
    e.ra = w[25:21];
    e.rb = w[20:16];
    e.wa = w[15:11];
    e.op = op;
    e.rw = w[15:11] != 5'd0;
    e.cnt = 16'(cnt);
    return e;
  endfunction
  task automatic accept(input logic [31:0] w);
    bit r, acc;
    acc = 0;
    inst = w;
    inst_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      r = inst_ready;
      @(posedge clk);
      acc = r;
    end
    #1;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept required accept within 20 cycles");
    end
  endtask
  task automatic send(input logic [31:0] w, input logic [3:0] op, input bit legal);
    int lat;
    if (legal) begin
      cnt_m++;
      q.push_back(mk(w, op, cnt_m));
    end
    accept(w);
    chk("dec_ready_low", 32'(inst_ready), 32'd0);
    chk("dec_addr_a", 32'(R_Addr_A), 32'(w[25:21]));
    chk("dec_addr_b", 32'(R_Addr_B), 32'(w[20:16]));
    if (legal) chk("dec_alu_op", 32'(ALU_OP), 32'(op));
    lat = 0;
    while (!inst_ready && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("ready_latency", 32'(lat), legal ? 32'd4 : 32'd2);
    if (!legal) ill_m = 1;
    chk("ill_flag", 32'(ill_flag), 32'(ill_m));
    chk("cnt_idle", 32'(inst_cnt), 32'(cnt_m));
  endtask
  initial begin
    logic [5:0] fn[8] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h20, 6'h22, 6'h2B, 6'h04};
    logic [31:0] w;
    #12;
    chk("rst_ready", 32'(inst_ready), 32'd1);
    chk("rst_strobes", 32'({clk_RR, clk_F, clk_WB, Reg_Write}), 32'd0);
    chk("rst_cnt", 32'(inst_cnt), 32'd0);
    chk("rst_ill", 32'(ill_flag), 32'd0);
    chk("rst_addrs", 32'({R_Addr_A, R_Addr_B, W_Addr, ALU_OP}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'h00A63020, 4'b0100, 1);
    inst_valid = 1'b0;
    @(posedge clk);
    #1;
    send(32'h00221824, 4'b0000, 1);
    send(32'h00E82025, 4'b0001, 1);
    send(32'h03E0F822, 4'b0101, 1);
    inst_valid = 1'b0;
    chk("b2b_cnt", 32'(inst_cnt), 32'd4);
    send(32'h00220024, 4'b0000, 1);
    chk("ill_before", 32'(ill_flag), 32'd0);
    send(32'h8C220000, 4'b0000, 0);
    send(32'h00221021, 4'b0000, 0);
    inst_valid = 1'b0;
    chk("ill_sticky", 32'(ill_flag), 32'd1);
    q.push_back(mk(32'h00A63020, 4'b0100, cnt_m + 1));
    accept(32'h00A63020);
    inst_valid = 1'b0;
    for (int i = 0; i < 10 && !clk_F; i++) @(negedge clk);
    chk("reached_ex", 32'(clk_F), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_f_drop", 32'(clk_F), 32'd0);
    chk("arst_rw_drop", 32'(Reg_Write), 32'd0);
    chk("arst_ready", 32'(inst_ready), 32'd1);
    chk("arst_cnt", 32'(inst_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_m = 0;
    ill_m = 0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(inst_ready), 32'd1);
    chk("post_rst_ill", 32'(ill_flag), 32'd0);
    chk("post_rst_cnt", 32'(inst_cnt), 32'd0);
    for (int i = 0; i < 16; i++) begin
      w = {6'd0, 5'(i), 5'(i + 9), 5'(i), 5'(i), fn[i % 8]};
      send(w, 4'(i % 8), 1);
    end
    inst_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_cnt", 32'(inst_cnt), 32'd16);
    chk("wrap_cnt4", 32'(inst_cnt_4), 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
